// File: rtl/lrelu_pkg.sv
// Shared definitions for the LReLU engine and its upstream config sequencer.
package lrelu_pkg;

    // Sequencer phase: first config beat, remaining config beats, conv data.
    typedef enum logic [1:0] {
        CFG_FIRST = 2'd0,
        CFG_REST  = 2'd1,
        DATA      = 2'd2
    } seq_state_e;

    // tuser bit positions understood by the engine.
    localparam int I_IS_1X1 = 5;

    // Config beats per iteration; the engine's config counter uses the same values.
    localparam int CONFIG_BEATS_3X3 = 21;
    localparam int CONFIG_BEATS_1X1 = 13;

    // Width of the remaining-beats counter inside a config burst.
    localparam int CFG_COUNT_W = 8;

    // Remaining beats after the first one, minus one, so the final beat sees zero.
    function automatic logic [CFG_COUNT_W-1:0] cfg_rest_count(
        input logic is_1x1,
        input int   beats_3x3,
        input int   beats_1x1
    );
        int beats;
        beats = is_1x1 ? beats_1x1 : beats_3x3;
        return CFG_COUNT_W'(beats - 2);
    endfunction

endpackage

// File: rtl/axis_skid_buffer_2.sv
// Two-entry AXI-Stream register slice: one cycle latency, full throughput,
// input ready depends only on local flops.
module axis_skid_buffer_2 #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic         out_valid_q, out_valid_d;
    logic [W-1:0] out_data_q,  out_data_d;
    logic         skid_valid_q, skid_valid_d;
    logic [W-1:0] skid_data_q,  skid_data_d;
    logic         push_s;
    logic         pop_s;

    assign in_ready  = ~skid_valid_q;
    assign push_s    = in_valid & ~skid_valid_q;
    assign pop_s     = out_valid_q & out_ready;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

    // Next-state of the output slot and the skid slot.
    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        if (!out_valid_q || pop_s) begin
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_data_d   = skid_data_q;
                skid_valid_d = push_s;
                skid_data_d  = push_s ? in_data : skid_data_q;
            end else begin
                out_valid_d  = push_s;
                out_data_d   = push_s ? in_data : out_data_q;
            end
        end else begin
            if (push_s) begin
                skid_valid_d = 1'b1;
                skid_data_d  = in_data;
            end else begin
                skid_valid_d = skid_valid_q;
            end
        end
    end

    // Buffer registers; reset empties both slots.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
        end
    end

endmodule

// File: rtl/axis_lrelu_config_sequencer.sv
// Merges the requant config stream and the conv data stream into the single
// stream the LReLU engine consumes: one config burst, then one data iteration.
module axis_lrelu_config_sequencer
    import lrelu_pkg::*;
#(
    parameter int WORD_WIDTH       = 1024,
    parameter int TUSER_WIDTH      = 8,
    parameter int I_IS_1X1_P       = I_IS_1X1,
    parameter int CONFIG_BEATS_3X3_P = CONFIG_BEATS_3X3,
    parameter int CONFIG_BEATS_1X1_P = CONFIG_BEATS_1X1,
    parameter int ITER_BITS        = 16
) (
    input  logic                   aclk,
    input  logic                   areset,
    input  logic                   s_config_tvalid,
    output logic                   s_config_tready,
    input  logic [WORD_WIDTH-1:0]  s_config_tdata,
    input  logic                   s_config_tuser,
    input  logic                   s_config_tlast,
    input  logic                   s_data_tvalid,
    output logic                   s_data_tready,
    input  logic [WORD_WIDTH-1:0]  s_data_tdata,
    input  logic [TUSER_WIDTH-1:0] s_data_tuser,
    input  logic                   s_data_tlast,
    output logic                   m_tvalid,
    input  logic                   m_tready,
    output logic [WORD_WIDTH-1:0]  m_tdata,
    output logic [TUSER_WIDTH-1:0] m_tuser,
    output logic                   m_tlast,
    output logic [ITER_BITS-1:0]   iter_count,
    output logic                   err_config,
    input  logic                   err_clear
);

    localparam int BW = WORD_WIDTH + TUSER_WIDTH + 1;

    seq_state_e             state_q, state_d;
    logic [CFG_COUNT_W-1:0] count_q, count_d;
    logic                   is_1x1_q, is_1x1_d;
    logic [ITER_BITS-1:0]   iter_q, iter_d;
    logic                   err_q, err_d;

    logic                   buf_ready_s;
    logic                   in_cfg_s;
    logic                   cfg_hs_s;
    logic                   data_hs_s;
    logic                   err_set_s;
    logic                   push_valid_s;
    logic [WORD_WIDTH-1:0]  push_tdata_s;
    logic [TUSER_WIDTH-1:0] push_tuser_s;
    logic                   push_tlast_s;

    assign in_cfg_s        = (state_q == CFG_FIRST) || (state_q == CFG_REST);
    assign s_config_tready = buf_ready_s & in_cfg_s;
    assign s_data_tready   = buf_ready_s & (state_q == DATA);
    assign cfg_hs_s        = s_config_tvalid & s_config_tready;
    assign data_hs_s       = s_data_tvalid & s_data_tready;
    assign iter_count      = iter_q;
    assign err_config      = err_q;

    // Source selection, beat formatting and sequencing decisions.
    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        is_1x1_d     = is_1x1_q;
        iter_d       = iter_q;
        err_set_s    = 1'b0;
        push_valid_s = 1'b0;
        push_tdata_s = s_config_tdata;
        push_tuser_s = '0;
        push_tlast_s = 1'b0;
        case (state_q)
            CFG_FIRST: begin
                push_valid_s             = s_config_tvalid;
                push_tuser_s[I_IS_1X1_P] = s_config_tuser;
                if (cfg_hs_s) begin
                    is_1x1_d  = s_config_tuser;
                    count_d   = cfg_rest_count(s_config_tuser, CONFIG_BEATS_3X3_P,
                                               CONFIG_BEATS_1X1_P);
                    state_d   = CFG_REST;
                    err_set_s = s_config_tlast;
                end else begin
                    state_d = CFG_FIRST;
                end
            end
            CFG_REST: begin
                push_valid_s             = s_config_tvalid;
                push_tuser_s[I_IS_1X1_P] = is_1x1_q;
                if (cfg_hs_s) begin
                    err_set_s = s_config_tlast != (count_q == '0);
                    if (count_q == '0) begin
                        state_d = DATA;
                    end else begin
                        count_d = count_q - CFG_COUNT_W'(1);
                    end
                end else begin
                    state_d = CFG_REST;
                end
            end
            DATA: begin
                push_valid_s = s_data_tvalid;
                push_tdata_s = s_data_tdata;
                push_tuser_s = s_data_tuser;
                push_tlast_s = s_data_tlast;
                if (data_hs_s && s_data_tlast) begin
                    iter_d  = iter_q + ITER_BITS'(1);
                    state_d = CFG_FIRST;
                end else begin
                    state_d = DATA;
                end
            end
            default: begin
                state_d = CFG_FIRST;
            end
        endcase
        if (err_set_s) begin
            err_d = 1'b1;
        end else if (err_clear) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end
    end

    // Sequencer state and status registers.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q  <= CFG_FIRST;
            count_q  <= '0;
            is_1x1_q <= 1'b0;
            iter_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            is_1x1_q <= is_1x1_d;
            iter_q   <= iter_d;
            err_q    <= err_d;
        end
    end

    axis_skid_buffer_2 #(
        .W (BW)
    ) u_out_buf (
        .clk       (aclk),
        .rst       (areset),
        .in_valid  (push_valid_s),
        .in_ready  (buf_ready_s),
        .in_data   ({push_tdata_s, push_tuser_s, push_tlast_s}),
        .out_valid (m_tvalid),
        .out_ready (m_tready),
        .out_data  ({m_tdata, m_tuser, m_tlast})
    );

endmodule

// File: tb/tb_axis_lrelu_config_sequencer.sv
// Directed, table-driven bench for axis_lrelu_config_sequencer.
module tb_axis_lrelu_config_sequencer;

    localparam int WW = 32;
    localparam int TW = 8;
    localparam int IB = 16;

    logic          aclk = 1'b0;
    logic          areset;
    logic          s_config_tvalid, s_config_tready;
    logic [WW-1:0] s_config_tdata;
    logic          s_config_tuser, s_config_tlast;
    logic          s_data_tvalid, s_data_tready;
    logic [WW-1:0] s_data_tdata;
    logic [TW-1:0] s_data_tuser;
    logic          s_data_tlast;
    logic          m_tvalid, m_tready;
    logic [WW-1:0] m_tdata;
    logic [TW-1:0] m_tuser;
    logic          m_tlast;
    logic [IB-1:0] iter_count;
    logic          err_config, err_clear;

    always #5 aclk = ~aclk;

    axis_lrelu_config_sequencer #(
        .WORD_WIDTH  (WW),
        .TUSER_WIDTH (TW),
        .ITER_BITS   (IB)
    ) dut (
        .aclk            (aclk),
        .areset          (areset),
        .s_config_tvalid (s_config_tvalid),
        .s_config_tready (s_config_tready),
        .s_config_tdata  (s_config_tdata),
        .s_config_tuser  (s_config_tuser),
        .s_config_tlast  (s_config_tlast),
        .s_data_tvalid   (s_data_tvalid),
        .s_data_tready   (s_data_tready),
        .s_data_tdata    (s_data_tdata),
        .s_data_tuser    (s_data_tuser),
        .s_data_tlast    (s_data_tlast),
        .m_tvalid        (m_tvalid),
        .m_tready        (m_tready),
        .m_tdata         (m_tdata),
        .m_tuser         (m_tuser),
        .m_tlast         (m_tlast),
        .iter_count      (iter_count),
        .err_config      (err_config),
        .err_clear       (err_clear)
    );

    typedef struct {
        bit is_1x1;     // tuser on the first config beat
        int n_cfg;      // config beats the engine expects (21 or 13)
        int n_dat;      // data beats, tlast on the last one
        int tlast_beat; // 1-based config beat carrying tlast, 0 = none
        bit bp;         // random m_tready
        bit clr_hold;   // err_clear held high during the run
        bit exp_err;    // err_config after the run
        int exp_iter;   // iter_count after the run
    } iter_vec_t;

    iter_vec_t vecs[6];
    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [WW-1:0] cfg_word(input int id, input int i);
        return 32'hC000_0000 + WW'(id) * 32'h0001_0000 + WW'(i);
    endfunction

    function automatic logic [WW-1:0] dat_word(input int id, input int k);
        return 32'hD000_0000 + WW'(id) * 32'h0001_0000 + WW'(k);
    endfunction

    function automatic logic [TW-1:0] dat_user(input int k);
        return TW'(k * 37 + 1);
    endfunction

    task automatic idle_inputs();
        s_config_tvalid = 1'b0;
        s_config_tdata  = '0;
        s_config_tuser  = 1'b0;
        s_config_tlast  = 1'b0;
        s_data_tvalid   = 1'b0;
        s_data_tdata    = '0;
        s_data_tuser    = '0;
        s_data_tlast    = 1'b0;
    endtask

    // One iteration: both sources offered from the first cycle, m stream checked beat by beat.
    task automatic run_iter(input iter_vec_t v, input int id);
        int  ci, di, mi, cyc, total, k;
        bit  chk_next, cfg_hs, dat_hs;
        logic [WW-1:0] e_data;
        logic [TW-1:0] e_user;
        logic          e_last;
        ci = 0; di = 0; mi = 0; cyc = 0; chk_next = 1'b0;
        total = v.n_cfg + v.n_dat;
        err_clear = v.clr_hold;
        while (mi < total && cyc < 3000) begin
            @(negedge aclk);
            if (chk_next) begin
                check($sformatf("err_next_cycle[%0d]", id), 64'(err_config), 64'd1);
                chk_next = 1'b0;
            end
            s_config_tvalid = ci < v.n_cfg;
            s_config_tdata  = cfg_word(id, ci);
            s_config_tuser  = (ci == 0) ? v.is_1x1 : ~v.is_1x1;
            s_config_tlast  = (ci + 1 == v.tlast_beat);
            s_data_tvalid   = di < v.n_dat;
            s_data_tdata    = dat_word(id, di);
            s_data_tuser    = dat_user(di);
            s_data_tlast    = (di == v.n_dat - 1);
            m_tready        = v.bp ? 1'($urandom_range(0, 1)) : 1'b1;
            if (ci < v.n_cfg) begin
                check($sformatf("data_ready_in_cfg[%0d]", id), 64'(s_data_tready), 64'd0);
            end
            cfg_hs = s_config_tvalid && s_config_tready;
            dat_hs = s_data_tvalid && s_data_tready;
            if (m_tvalid && m_tready) begin
                if (mi < v.n_cfg) begin
                    e_data = cfg_word(id, mi);
                    e_user = v.is_1x1 ? 8'h20 : 8'h00;
                    e_last = 1'b0;
                end else begin
                    k      = mi - v.n_cfg;
                    e_data = dat_word(id, k);
                    e_user = dat_user(k);
                    e_last = (k == v.n_dat - 1);
                end
                check($sformatf("m_beat[%0d.%0d]", id, mi),
                      {23'd0, m_tlast, m_tuser, m_tdata}, {23'd0, e_last, e_user, e_data});
                mi++;
            end
            if (cfg_hs) begin
                if (s_config_tlast != (ci == v.n_cfg - 1)) chk_next = 1'b1;
                ci++;
            end
            if (dat_hs) di++;
            cyc++;
        end
        check($sformatf("beats_in_budget[%0d]", id), 64'(mi), 64'(total));
        @(negedge aclk);
        idle_inputs();
        err_clear = 1'b0;
        m_tready  = 1'b1;
        check($sformatf("iter_count[%0d]", id), 64'(iter_count), 64'(v.exp_iter));
        check($sformatf("err_config[%0d]", id), 64'(err_config), 64'(v.exp_err));
        check($sformatf("m_empty_after[%0d]", id), 64'(m_tvalid), 64'd0);
        check($sformatf("back_to_cfg[%0d]", id), {62'd0, s_config_tready, s_data_tready}, 64'd2);
        if (!v.bp) begin
            check($sformatf("throughput_cycles[%0d]", id), 64'(cyc), 64'(total + 1));
        end
        err_clear = 1'b1;
        @(negedge aclk);
        err_clear = 1'b0;
        check($sformatf("err_cleared[%0d]", id), 64'(err_config), 64'd0);
    endtask

    initial begin
        iter_vec_t rv;
        int        i;
        vecs[0] = '{is_1x1: 1'b0, n_cfg: 21, n_dat: 50, tlast_beat: 21, bp: 1'b0, clr_hold: 1'b0, exp_err: 1'b0, exp_iter: 1};
        vecs[1] = '{is_1x1: 1'b1, n_cfg: 13, n_dat: 10, tlast_beat: 13, bp: 1'b0, clr_hold: 1'b0, exp_err: 1'b0, exp_iter: 2};
        vecs[2] = '{is_1x1: 1'b0, n_cfg: 21, n_dat: 8,  tlast_beat: 21, bp: 1'b1, clr_hold: 1'b0, exp_err: 1'b0, exp_iter: 3};
        vecs[3] = '{is_1x1: 1'b1, n_cfg: 13, n_dat: 5,  tlast_beat: 13, bp: 1'b1, clr_hold: 1'b0, exp_err: 1'b0, exp_iter: 4};
        vecs[4] = '{is_1x1: 1'b0, n_cfg: 21, n_dat: 4,  tlast_beat: 5,  bp: 1'b0, clr_hold: 1'b0, exp_err: 1'b1, exp_iter: 5};
        vecs[5] = '{is_1x1: 1'b0, n_cfg: 21, n_dat: 3,  tlast_beat: 0,  bp: 1'b1, clr_hold: 1'b1, exp_err: 1'b0, exp_iter: 6};

        areset    = 1'b1;
        err_clear = 1'b0;
        m_tready  = 1'b0;
        idle_inputs();
        repeat (3) @(negedge aclk);
        areset = 1'b0;
        @(negedge aclk);
        check("reset_m_tvalid", 64'(m_tvalid), 64'd0);
        check("reset_iter_count", 64'(iter_count), 64'd0);
        check("reset_err_config", 64'(err_config), 64'd0);
        check("reset_readies", {62'd0, s_config_tready, s_data_tready}, 64'd2);

        for (int n = 0; n < 6; n++) begin
            run_iter(vecs[n], n);
        end

        // Reset in the middle of a config burst, then a fresh 1x1 burst.
        i = 0;
        while (i < 7) begin
            @(negedge aclk);
            s_config_tvalid = 1'b1;
            s_config_tdata  = cfg_word(9, i);
            s_config_tuser  = 1'b0;
            s_config_tlast  = 1'b0;
            s_data_tvalid   = 1'b1;
            m_tready        = 1'b1;
            if (s_config_tready) i++;
        end
        @(negedge aclk);
        s_config_tdata = cfg_word(9, 7);
        #2 areset = 1'b1;
        #1;
        check("midburst_reset_m_tvalid", 64'(m_tvalid), 64'd0);
        check("midburst_reset_iter", 64'(iter_count), 64'd0);
        check("midburst_reset_data_ready", 64'(s_data_tready), 64'd0);
        @(negedge aclk);
        areset = 1'b0;
        idle_inputs();
        rv = '{is_1x1: 1'b1, n_cfg: 13, n_dat: 2, tlast_beat: 13, bp: 1'b0, clr_hold: 1'b0, exp_err: 1'b0, exp_iter: 1};
        run_iter(rv, 7);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/axis_lrelu_config_sequencer.md
Name: axis_lrelu_config_sequencer

Overview:
- Upstream scheduler for the LReLU engine's slave port. It merges two AXI-Stream sources into the single stream the engine consumes: a config stream (D/A/B requant words) and the conv-output data stream.
- Per iteration it forwards exactly one config burst (21 beats for 3x3, 13 beats for 1x1), then data beats up to and including the data tlast, then returns to config.
- Drives tuser[I_IS_1X1] during config beats so the engine sizes its config load correctly.

Parameters:
- WORD_WIDTH, 1024, width of s_config_tdata, s_data_tdata and m_tdata (MEMBERS*COPIES*GROUPS*UNITS*WORD_WIDTH_IN).
- TUSER_WIDTH, 8, data/output tuser width.
- I_IS_1X1, 5, index of the is_1x1 bit in tuser.
- CONFIG_BEATS_3X3, 21, total config beats per 3x3 iteration; must be >= 2.
- CONFIG_BEATS_1X1, 13, total config beats per 1x1 iteration; must be >= 2.
- ITER_BITS, 16, width of the iteration counter.

Ports:
- aclk, in, 1, clock.
- areset, in, 1, asynchronous active-high reset.
- s_config_tvalid, in, 1, config stream valid.
- s_config_tready, out, 1, config stream ready.
- s_config_tdata, in, WORD_WIDTH, config words.
- s_config_tuser, in, 1, is_1x1 for this burst; sampled on the first beat only.
- s_config_tlast, in, 1, marks the last config beat of a burst.
- s_data_tvalid, in, 1, conv data valid.
- s_data_tready, out, 1, conv data ready.
- s_data_tdata, in, WORD_WIDTH, conv data.
- s_data_tuser, in, TUSER_WIDTH, conv tuser.
- s_data_tlast, in, 1, last beat of the iteration.
- m_tvalid, out, 1, to engine slave valid.
- m_tready, in, 1, from engine slave ready.
- m_tdata, out, WORD_WIDTH, merged data.
- m_tuser, out, TUSER_WIDTH, merged tuser.
- m_tlast, out, 1, merged tlast.
- iter_count, out, ITER_BITS, number of completed iterations.
- err_config, out, 1, sticky: config burst length mismatch.
- err_clear, in, 1, synchronous clear of err_config.

Behaviour:
- States: CFG_FIRST, CFG_REST, DATA. Reset (async) state is CFG_FIRST.
- Reset values: count = 0, is_1x1_q = 0, iter_count = 0, err_config = 0, output buffer empty (m_tvalid = 0).
- Output path: a 2-entry skid buffer.
  - Latency is 1 cycle from an input handshake to m_tvalid.
  - Full throughput under continuous m_tready.
  - buf_ready = skid buffer has a free slot.
- CFG_FIRST:
  - s_config_tready = buf_ready; s_data_tready = 0.
  - On config handshake: is_1x1_q <= s_config_tuser; count <= (s_config_tuser ? CONFIG_BEATS_1X1 : CONFIG_BEATS_3X3) - 2; go to CFG_REST.
  - Pushed beat: tdata = s_config_tdata; tuser = 0 except bit I_IS_1X1 = s_config_tuser; tlast = 0.
- CFG_REST:
  - s_config_tready = buf_ready; s_data_tready = 0.
  - Pushed beat: tuser bit I_IS_1X1 = is_1x1_q, all other bits 0; tlast = 0.
  - On handshake: if count == 0, go to DATA; else count <= count - 1.
- DATA:
  - s_data_tready = buf_ready; s_config_tready = 0.
  - Beats pass through unchanged (tdata, tuser, tlast).
  - On a handshake with s_data_tlast = 1: iter_count <= iter_count + 1 (wraps modulo 2^ITER_BITS); go to CFG_FIRST.
- Source isolation: s_data_tvalid is ignored in the CFG states and s_config_tvalid is ignored in DATA. No beat is ever dropped or duplicated.
- Config tlast check:
  - err_config is set if s_config_tlast = 1 on a handshake that is not the final beat (early tlast).
  - err_config is set if s_config_tlast = 0 on the final beat (count == 0 in CFG_REST).
  - The sequence still advances using the count; tlast does not change the beat count.
  - err_clear clears err_config; if a set event occurs in the same cycle, set wins.
- No mid-burst switching: once CFG_FIRST accepts a beat, the sequencer stays on the config source until the burst completes.
- Reset mid-burst or mid-data:
  - Async return to CFG_FIRST; the skid buffer is emptied.
  - The engine must be reset simultaneously by the system.

Decomposition:
- Shared package lrelu_pkg: state encoding; I_IS_* indices; CONFIG_BEATS_3X3 / CONFIG_BEATS_1X1 constants, which are shared with the engine's config counter.
- One sub-module: axis_skid_buffer_2, a parameterised 2-entry register slice carrying {tdata, tuser, tlast}.

Test Plan:
- 3x3 iteration: 21 config beats with tuser=0 and tlast on beat 21, then 50 data beats with tlast on beat 50 -> m carries exactly 71 beats in order; m_tuser[5] = 0 on config beats; iter_count = 1; err_config = 0.
- 1x1 iteration: 13 config beats with tuser=1, then 10 data beats -> m_tuser[5] = 1 on all 13 config beats; the state returns to DATA after beat 13; s_data_tready = 0 throughout the config phase.
- Backpressure: m_tready toggling randomly at 50%, with both sources always valid -> no loss or duplication; the config and data orders are preserved; throughput reaches 1 beat/cycle once m_tready is held at 1.
- Early config tlast on beat 5 of a 3x3 burst -> err_config = 1 the next cycle; all 21 config beats are still forwarded before data; err_clear -> err_config = 0.
- Data valid asserted during the config phase with a 21-beat burst -> s_data_tready = 0 throughout; the first data beat appears on m only after config beat 21.
- areset asserted during config beat 7 -> immediately m_tvalid = 0 and iter_count = 0; after release the next config beat is treated as the first beat (its tuser is sampled).
